// File: rtl/dtm_jtag_tap.sv
// IEEE 1149.1 TAP controller for the RISC-V debug transport module.
// Owns the TAP FSM, the 5-bit IR, IDCODE and BYPASS; DTMCS/DMI registers live outside.
module dtm_jtag_tap #(
  parameter int unsigned IrLength    = 5,
  parameter logic [31:0] IdCodeValue = 32'h0000_0001
) (
  input  logic tck_i,
  input  logic trst_ni,
  input  logic tms_i,
  input  logic td_i,
  output logic td_o,
  output logic tdo_oe_o,
  output logic dmi_clear_o,
  output logic update_o,
  output logic capture_o,
  output logic shift_o,
  output logic tdi_o,
  output logic tck_o,
  output logic dtmcs_select_o,
  input  logic dtmcs_tdo_i,
  output logic dmi_select_o,
  input  logic dmi_tdo_i
);

  localparam logic [3:0] TestLogicReset = 4'd0;
  localparam logic [3:0] RunTestIdle    = 4'd1;
  localparam logic [3:0] SelectDrScan   = 4'd2;
  localparam logic [3:0] CaptureDr      = 4'd3;
  localparam logic [3:0] ShiftDr        = 4'd4;
  localparam logic [3:0] Exit1Dr        = 4'd5;
  localparam logic [3:0] PauseDr        = 4'd6;
  localparam logic [3:0] Exit2Dr        = 4'd7;
  localparam logic [3:0] UpdateDr       = 4'd8;
  localparam logic [3:0] SelectIrScan   = 4'd9;
  localparam logic [3:0] CaptureIr      = 4'd10;
  localparam logic [3:0] ShiftIr        = 4'd11;
  localparam logic [3:0] Exit1Ir        = 4'd12;
  localparam logic [3:0] PauseIr        = 4'd13;
  localparam logic [3:0] Exit2Ir        = 4'd14;
  localparam logic [3:0] UpdateIr       = 4'd15;

  localparam logic [IrLength-1:0] IrIdcode    = IrLength'('h01);
  localparam logic [IrLength-1:0] IrDtmcs     = IrLength'('h10);
  localparam logic [IrLength-1:0] IrDmiAccess = IrLength'('h11);
  localparam logic [IrLength-1:0] IrCapture   = IrLength'('b00101);

  logic [3:0]          state_q, state_d;
  logic [IrLength-1:0] ir_q, ir_d;
  logic [IrLength-1:0] ir_sr_q, ir_sr_d;
  logic [31:0]         idcode_q, idcode_d;
  logic                bypass_q, bypass_d;
  logic                td_q, tdo_oe_q;
  logic                idcode_select, tdo_mux;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TestLogicReset: state_d = tms_i ? TestLogicReset : RunTestIdle;
      RunTestIdle:    state_d = tms_i ? SelectDrScan   : RunTestIdle;
      SelectDrScan:   state_d = tms_i ? SelectIrScan   : CaptureDr;
      CaptureDr:      state_d = tms_i ? Exit1Dr        : ShiftDr;
      ShiftDr:        state_d = tms_i ? Exit1Dr        : ShiftDr;
      Exit1Dr:        state_d = tms_i ? UpdateDr       : PauseDr;
      PauseDr:        state_d = tms_i ? Exit2Dr        : PauseDr;
      Exit2Dr:        state_d = tms_i ? UpdateDr       : ShiftDr;
      UpdateDr:       state_d = tms_i ? SelectDrScan   : RunTestIdle;
      SelectIrScan:   state_d = tms_i ? TestLogicReset : CaptureIr;
      CaptureIr:      state_d = tms_i ? Exit1Ir        : ShiftIr;
      ShiftIr:        state_d = tms_i ? Exit1Ir        : ShiftIr;
      Exit1Ir:        state_d = tms_i ? UpdateIr       : PauseIr;
      PauseIr:        state_d = tms_i ? Exit2Ir        : PauseIr;
      Exit2Ir:        state_d = tms_i ? UpdateIr       : ShiftIr;
      UpdateIr:       state_d = tms_i ? SelectDrScan   : RunTestIdle;
      default:        state_d = TestLogicReset;
    endcase
  end

  assign idcode_select  = (ir_q == IrIdcode);
  assign dtmcs_select_o = (ir_q == IrDtmcs);
  assign dmi_select_o   = (ir_q == IrDmiAccess);

  always_comb begin
    ir_sr_d = ir_sr_q;
    ir_d    = ir_q;
    if (state_q == CaptureIr) ir_sr_d = IrCapture;
    if (state_q == ShiftIr)   ir_sr_d = {td_i, ir_sr_q[IrLength-1:1]};
    if (state_q == UpdateIr)  ir_d    = ir_sr_q;
    if (state_q == TestLogicReset) ir_d = IrIdcode;
  end

  // IDCODE only moves while it is the selected DR; BYPASS is the default path.
  always_comb begin
    idcode_d = idcode_q;
    bypass_d = bypass_q;
    if (state_q == CaptureDr) begin
      bypass_d = 1'b0;
      if (idcode_select) idcode_d = IdCodeValue;
    end
    if (state_q == ShiftDr) begin
      bypass_d = td_i;
      if (idcode_select) idcode_d = {td_i, idcode_q[31:1]};
    end
  end

  always_comb begin
    tdo_mux = bypass_q;
    if (state_q == ShiftIr)  tdo_mux = ir_sr_q[0];
    else if (idcode_select)  tdo_mux = idcode_q[0];
    else if (dtmcs_select_o) tdo_mux = dtmcs_tdo_i;
    else if (dmi_select_o)   tdo_mux = dmi_tdo_i;
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q  <= TestLogicReset;
      ir_q     <= IrIdcode;
      ir_sr_q  <= '0;
      idcode_q <= '0;
      bypass_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      ir_sr_q  <= ir_sr_d;
      idcode_q <= idcode_d;
      bypass_q <= bypass_d;
    end
  end

  // TDO launches on the falling edge so the host samples it cleanly on the next rise.
  always_ff @(negedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      td_q     <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      td_q     <= tdo_mux;
      tdo_oe_q <= (state_q == ShiftIr) || (state_q == ShiftDr);
    end
  end

  assign td_o        = td_q;
  assign tdo_oe_o    = tdo_oe_q;
  assign dmi_clear_o = (state_q == TestLogicReset);
  assign capture_o   = (state_q == CaptureDr);
  assign shift_o     = (state_q == ShiftDr);
  assign update_o    = (state_q == UpdateDr);
  assign tdi_o       = td_i;
  assign tck_o       = tck_i;

endmodule

// File: tb/tb_dtm_jtag_tap.sv
// Bench for dtm_jtag_tap: table-driven TAP model checked every tick, plus directed scans.
module tb_dtm_jtag_tap;

  localparam logic [31:0] IDV = 32'hDEADBEEF;

  logic tck_i = 1'b0, trst_ni = 1'b1, tms_i = 1'b1, td_i = 1'b0;
  logic dtmcs_tdo_i = 1'b0, dmi_tdo_i = 1'b0;
  logic td_o, tdo_oe_o, dmi_clear_o, update_o, capture_o, shift_o, tdi_o, tck_o;
  logic dtmcs_select_o, dmi_select_o;

  int tests = 0;
  int fails = 0;

  dtm_jtag_tap #(.IrLength(5), .IdCodeValue(IDV)) dut (
    .tck_i(tck_i), .trst_ni(trst_ni), .tms_i(tms_i), .td_i(td_i),
    .td_o(td_o), .tdo_oe_o(tdo_oe_o), .dmi_clear_o(dmi_clear_o),
    .update_o(update_o), .capture_o(capture_o), .shift_o(shift_o),
    .tdi_o(tdi_o), .tck_o(tck_o), .dtmcs_select_o(dtmcs_select_o),
    .dtmcs_tdo_i(dtmcs_tdo_i), .dmi_select_o(dmi_select_o), .dmi_tdo_i(dmi_tdo_i)
  );

  always #5 tck_i = ~tck_i;

  // State indices: 0 TLR,1 RTI,2 SelDR,3 CapDR,4 ShDR,5 Ex1DR,6 PDR,7 Ex2DR,8 UpdDR,
  // 9 SelIR,10 CapIR,11 ShIR,12 Ex1IR,13 PIR,14 Ex2IR,15 UpdIR
  int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  int          m_state;
  logic [4:0]  m_ir, m_irsr;
  logic [31:0] m_id;
  logic        m_byp;

  task automatic model_reset();
    m_state = 0; m_ir = 5'h01; m_irsr = 5'h00; m_id = 32'h0; m_byp = 1'b0;
  endtask

  task automatic model_step(input logic tms, input logic tdi);
    if (m_state == 10)      m_irsr = 5'b00101;
    else if (m_state == 11) m_irsr = {tdi, m_irsr[4:1]};
    else if (m_state == 15) m_ir = m_irsr;
    else if (m_state == 0)  m_ir = 5'h01;
    if (m_state == 3) begin
      m_byp = 1'b0;
      if (m_ir == 5'h01) m_id = IDV;
    end else if (m_state == 4) begin
      m_byp = tdi;
      if (m_ir == 5'h01) m_id = {tdi, m_id[31:1]};
    end
    m_state = tms ? nxt1[m_state] : nxt0[m_state];
  endtask

  // obs/exp layout: {dmi_clear, capture, shift, update, dtmcs_sel, dmi_sel, td_o, tdo_oe}
  task automatic tick(input logic tms, input logic tdi,
                      output logic [7:0] obs, output logic [7:0] exp);
    logic dt, dm;
    dt = 1'($urandom); dm = 1'($urandom);
    tms_i = tms; td_i = tdi; dtmcs_tdo_i = dt; dmi_tdo_i = dm;
    @(posedge tck_i);
    model_step(tms, tdi);
    #1;
    obs[7:2] = {dmi_clear_o, capture_o, shift_o, update_o, dtmcs_select_o, dmi_select_o};
    exp[7:2] = {m_state == 0, m_state == 3, m_state == 4, m_state == 8,
                m_ir == 5'h10, m_ir == 5'h11};
    @(negedge tck_i); #1;
    obs[1:0] = {td_o, tdo_oe_o};
    if (m_state == 11)       exp[1] = m_irsr[0];
    else if (m_ir == 5'h01)  exp[1] = m_id[0];
    else if (m_ir == 5'h10)  exp[1] = dt;
    else if (m_ir == 5'h11)  exp[1] = dm;
    else                     exp[1] = m_byp;
    exp[0] = (m_state == 11) || (m_state == 4);
  endtask

  // Full scan starting and ending in Run-Test/Idle; returns collected TDO bits and strobe counts.
  task automatic scan(input bit is_ir, input int n, input logic [63:0] din,
                      output logic [63:0] dout, output logic [7:0] diff,
                      output int cap_n, output int sh_n, output int upd_n, output int oe_n);
    logic [7:0] o, e;
    int total;
    logic tms_seq [$];
    logic tdi_seq [$];
    dout = '0; diff = '0; cap_n = 0; sh_n = 0; upd_n = 0; oe_n = 0;
    tms_seq.push_back(1'b1); tdi_seq.push_back(1'b0);
    if (is_ir) begin tms_seq.push_back(1'b1); tdi_seq.push_back(1'b0); end
    tms_seq.push_back(1'b0); tdi_seq.push_back(1'b0);
    tms_seq.push_back(1'b0); tdi_seq.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      tms_seq.push_back(i == n - 1); tdi_seq.push_back(din[i]);
    end
    tms_seq.push_back(1'b1); tdi_seq.push_back(1'b0);
    tms_seq.push_back(1'b0); tdi_seq.push_back(1'b0);
    total = tms_seq.size();
    for (int k = 0; k < total; k++) begin
      tick(tms_seq[k], tdi_seq[k], o, e);
      diff  |= (o ^ e);
      cap_n += int'(o[6]); sh_n += int'(o[5]); upd_n += int'(o[4]); oe_n += int'(o[0]);
      // Bit j of the shift appears after the tick that lands on its position.
      if (k >= (is_ir ? 3 : 2) && k < (is_ir ? 3 : 2) + n)
        dout[k - (is_ir ? 3 : 2)] = o[1];
    end
  endtask

  task automatic test_reset();
    logic [7:0] o, e;
    #2 trst_ni = 1'b0;
    #1;
    tests++;
    if ({dmi_clear_o, capture_o, shift_o, update_o, dtmcs_select_o, dmi_select_o,
         td_o, tdo_oe_o} !== 8'h80) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected %b",
               {dmi_clear_o, capture_o, shift_o, update_o, dtmcs_select_o, dmi_select_o,
                td_o, tdo_oe_o}, 8'h80);
    end
    model_reset();
    @(negedge tck_i); #1 trst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'($urandom), o, e);
      tests++;
      if (o !== e || o[7] !== 1'b1) begin
        fails++;
        $display("FAIL tlr_hold[%0d]: got %b expected %b", i, o, e);
      end
    end
    tick(1'b0, 1'b0, o, e);
    tests++;
    if (o !== e) begin fails++; $display("FAIL enter_rti: got %b expected %b", o, e); end
  endtask

  task automatic test_idcode();
    logic [63:0] dout; logic [7:0] diff; int c, s, u, oe;
    scan(1'b0, 32, {$urandom, $urandom}, dout, diff, c, s, u, oe);
    tests++;
    if (dout[31:0] !== IDV) begin
      fails++; $display("FAIL idcode_value: got %h expected %h", dout[31:0], IDV);
    end
    tests++;
    if (oe != 32 || c != 1 || s != 32 || u != 1 || diff !== 8'h0) begin
      fails++;
      $display("FAIL idcode_strobes: got oe=%0d cap=%0d sh=%0d upd=%0d diff=%b expected 32/1/32/1/0",
               oe, c, s, u, diff);
    end
  endtask

  task automatic select_ir(input logic [4:0] op, input string name,
                           input logic exp_dtmcs, input logic exp_dmi);
    logic [63:0] dout; logic [7:0] diff; int c, s, u, oe;
    scan(1'b1, 5, {59'h0, op}, dout, diff, c, s, u, oe);
    tests++;
    if (dout[4:0] !== 5'b00101 || diff !== 8'h0 || oe != 5 || c != 0 || u != 0) begin
      fails++;
      $display("FAIL ir_scan_%s: got tdo=%b diff=%b oe=%0d expected tdo=00101 diff=0 oe=5",
               name, dout[4:0], diff, oe);
    end
    tests++;
    if ({dtmcs_select_o, dmi_select_o} !== {exp_dtmcs, exp_dmi}) begin
      fails++;
      $display("FAIL select_%s: got %b expected %b", name,
               {dtmcs_select_o, dmi_select_o}, {exp_dtmcs, exp_dmi});
    end
  endtask

  task automatic test_dmi();
    logic [63:0] dout; logic [7:0] diff; int c, s, u, oe;
    select_ir(5'h11, "dmi", 1'b0, 1'b1);
    scan(1'b0, 41, {$urandom, $urandom}, dout, diff, c, s, u, oe);
    tests++;
    if (c != 1 || s != 41 || u != 1 || oe != 41 || diff !== 8'h0) begin
      fails++;
      $display("FAIL dmi_scan: got cap=%0d sh=%0d upd=%0d oe=%0d diff=%b expected 1/41/1/41/0",
               c, s, u, oe, diff);
    end
  endtask

  task automatic test_dtmcs();
    logic [63:0] dout; logic [7:0] diff; int c, s, u, oe;
    select_ir(5'h10, "dtmcs", 1'b1, 1'b0);
    scan(1'b0, 32, {$urandom, $urandom}, dout, diff, c, s, u, oe);
    tests++;
    if (diff !== 8'h0 || s != 32) begin
      fails++; $display("FAIL dtmcs_scan: got diff=%b sh=%0d expected 0/32", diff, s);
    end
  endtask

  task automatic test_bypass(input logic [4:0] op, input int n, input logic [63:0] din);
    logic [63:0] dout, want; logic [7:0] diff; int c, s, u, oe;
    select_ir(op, $sformatf("byp%02h", op), 1'b0, 1'b0);
    scan(1'b0, n, din, dout, diff, c, s, u, oe);
    want = '0;
    for (int i = 1; i < n; i++) want[i] = din[i-1];
    tests++;
    if (dout !== want || diff !== 8'h0) begin
      fails++;
      $display("FAIL bypass_%02h: got %h diff=%b expected %h", op, dout, diff, want);
    end
  endtask

  task automatic test_random();
    logic [7:0] o, e, diff; int both;
    diff = '0; both = 0;
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 99) < 35), 1'($urandom), o, e);
      diff |= (o ^ e);
      if (o[3] && o[2]) both++;
      if (i % 50 == 49) begin
        tests++;
        if (diff !== 8'h0 || tdi_o !== td_i) begin
          fails++;
          $display("FAIL random_walk@%0d: got diff=%b tdi_o=%b expected diff=0 tdi_o=%b",
                   i, diff, tdi_o, td_i);
        end
        diff = '0;
      end
    end
    tests++;
    if (both != 0) begin fails++; $display("FAIL select_exclusive: got %0d expected 0", both); end
    // Five TMS=1 from wherever the walk ended must land in Test-Logic-Reset.
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, o, e);
    tests++;
    if (o[7] !== 1'b1 || o !== e) begin
      fails++; $display("FAIL five_tms_tlr: got %b expected %b", o, e);
    end
    tick(1'b0, 1'b0, o, e);
  endtask

  task automatic test_reset_mid_shift();
    logic [7:0] o, e; logic [63:0] dout; logic [7:0] diff; int c, s, u, oe;
    select_ir(5'h1F, "pre", 1'b0, 1'b0);
    tick(1'b1, 1'b0, o, e); tick(1'b1, 1'b0, o, e);
    tick(1'b0, 1'b0, o, e); tick(1'b0, 1'b0, o, e);
    tick(1'b0, 1'b0, o, e); tick(1'b0, 1'b1, o, e);
    tests++;
    if (o[0] !== 1'b1) begin fails++; $display("FAIL in_shift_ir: got oe=%b expected 1", o[0]); end
    trst_ni = 1'b0;
    #1;
    tests++;
    if ({dmi_clear_o, capture_o, shift_o, update_o, dtmcs_select_o, dmi_select_o,
         td_o, tdo_oe_o} !== 8'h80) begin
      fails++;
      $display("FAIL reset_mid_shift: got %b expected %b",
               {dmi_clear_o, capture_o, shift_o, update_o, dtmcs_select_o, dmi_select_o,
                td_o, tdo_oe_o}, 8'h80);
    end
    model_reset();
    #1 trst_ni = 1'b1;
    tick(1'b1, 1'b0, o, e);
    tick(1'b0, 1'b0, o, e);
    scan(1'b0, 32, 64'h0, dout, diff, c, s, u, oe);
    tests++;
    if (dout[31:0] !== IDV || diff !== 8'h0) begin
      fails++;
      $display("FAIL idcode_after_abort: got %h diff=%b expected %h", dout[31:0], diff, IDV);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idcode();
    test_dmi();
    test_dtmcs();
    test_bypass(5'h1F, 4, 64'hD);
    test_bypass(5'h05, 8, {32'h0, $urandom});
    test_bypass(5'h00, 16, {32'h0, $urandom});
    test_random();
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
